// File: rtl/math_game_pkg.sv
// Shared types and defaults for the math round engine.
package math_game_pkg;

    localparam int unsigned OPW_DEFAULT = 3;
    localparam int unsigned SCW_DEFAULT = 8;
    localparam int unsigned SESSION_SECS_DEFAULT = 30;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StGetA     = 3'd1,
        StGetB     = 3'd2,
        StAsk      = 3'd3,
        StFeedback = 3'd4,
        StDone     = 3'd5
    } state_e;

    // Busy covers every state that belongs to a running session.
    function automatic logic is_busy(input state_e s);
        return (s != StIdle) && (s != StDone);
    endfunction

endpackage

// File: rtl/session_timer.sv
// Counts tick_1s pulses during a session; flags the tick that ends it.
module session_timer #(
    parameter int unsigned SESSION_SECS = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick_en,
    output logic expire
);

    localparam int unsigned CW = $clog2(SESSION_SECS);

    logic [CW-1:0] count_q;

    assign expire = tick_en && (count_q == CW'(SESSION_SECS - 1));

    // Seconds elapsed; restarts on clear and after expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear || expire) begin
            count_q <= '0;
        end else if (tick_en) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/math_round_engine.sv
// Timed math session: operand fetch, question, grading and score.
// Optional build macro SCORE_PENALTY_EN: wrong answers decrement the score (floor 0).
module math_round_engine
    import math_game_pkg::*;
#(
    parameter int unsigned OPW          = OPW_DEFAULT,
    parameter int unsigned SESSION_SECS = SESSION_SECS_DEFAULT,
    parameter int unsigned SCW          = SCW_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic           donot_borrow,
    input  logic           tick_1s,
    input  logic           rng_valid,
    input  logic [OPW-1:0] rng_value,
    input  logic [OPW:0]   answer_sw,
    input  logic           answer_push,
    output logic           rng_req,
    output logic [OPW-1:0] operand_a,
    output logic [OPW-1:0] operand_b,
    output logic           op_sub,
    output logic [SCW-1:0] score,
    output logic           correct_led,
    output logic           wrong_led,
    output logic           busy,
    output logic           time_out
);

    state_e         state_q, state_d;
    logic [OPW-1:0] opa_q, opa_d, opb_q, opb_d;
    logic           sub_q, sub_d;
    logic [SCW-1:0] score_q, score_d;
    logic           cled_q, cled_d, wled_q, wled_d;
    logic           req_q, req_d;
    logic           tout_q, tout_d;
    logic           timer_clear, tick_en, expire, captured, b_sub;
    logic [OPW:0]   expected;

    assign busy    = is_busy(state_q);
    assign tick_en = tick_1s && busy && enable;

    session_timer #(
        .SESSION_SECS(SESSION_SECS)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .tick_en (tick_en),
        .expire  (expire)
    );

    // Answer computed in OPW+1 bits so subtraction wraps.
    assign expected = sub_q ? ({1'b0, opa_q} - {1'b0, opb_q}) : ({1'b0, opa_q} + {1'b0, opb_q});
    // Operation chosen from the freshly captured b and the held a.
    assign b_sub = opa_q[0] ^ rng_value[0];

    // Next-state and datapath updates; enable drop, then expiry, take priority.
    always_comb begin
        state_d     = state_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        sub_d       = sub_q;
        score_d     = score_q;
        cled_d      = cled_q;
        wled_d      = wled_q;
        tout_d      = 1'b0;
        timer_clear = 1'b0;
        captured    = 1'b0;
        if (!enable) begin
            state_d = StIdle;
            cled_d  = 1'b0;
            wled_d  = 1'b0;
        end else if (expire) begin
            state_d = StDone;
            tout_d  = 1'b1;
            cled_d  = 1'b0;
            wled_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d     = StGetA;
                    score_d     = '0;
                    timer_clear = 1'b1;
                end
                StGetA: begin
                    if (rng_valid) begin
                        opa_d    = rng_value;
                        captured = 1'b1;
                        state_d  = StGetB;
                    end
                end
                StGetB: begin
                    if (rng_valid) begin
                        captured = 1'b1;
                        sub_d    = b_sub;
                        state_d  = StAsk;
                        if (b_sub && donot_borrow && (opa_q < rng_value)) begin
                            opa_d = rng_value;
                            opb_d = opa_q;
                        end else begin
                            opb_d = rng_value;
                        end
                    end
                end
                StAsk: begin
                    if (answer_push) begin
                        state_d = StFeedback;
                        if (answer_sw == expected) begin
                            cled_d = 1'b1;
                            if (score_q != '1) score_d = score_q + 1'b1;
                        end else begin
                            wled_d = 1'b1;
`ifdef SCORE_PENALTY_EN
                            if (score_q != '0) score_d = score_q - 1'b1;
`endif
                        end
                    end
                end
                StFeedback: begin
                    if (tick_1s) begin
                        cled_d  = 1'b0;
                        wled_d  = 1'b0;
                        state_d = StGetA;
                    end
                end
                StDone: begin
                    cled_d = 1'b0;
                    wled_d = 1'b0;
                end
                default: state_d = StIdle;
            endcase
        end
        // Request drops for the cycle after each capture.
        req_d = ((state_d == StGetA) || (state_d == StGetB)) && !captured;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            opa_q   <= '0;
            opb_q   <= '0;
            sub_q   <= 1'b0;
            score_q <= '0;
            cled_q  <= 1'b0;
            wled_q  <= 1'b0;
            req_q   <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sub_q   <= sub_d;
            score_q <= score_d;
            cled_q  <= cled_d;
            wled_q  <= wled_d;
            req_q   <= req_d;
            tout_q  <= tout_d;
        end
    end

    assign rng_req     = req_q;
    assign operand_a   = opa_q;
    assign operand_b   = opb_q;
    assign op_sub      = sub_q;
    assign score       = score_q;
    assign correct_led = cled_q;
    assign wrong_led   = wled_q;
    assign time_out    = tout_q;

endmodule

// File: tb/tb_math_round_engine.sv
// Directed self-checking bench for math_round_engine (OPW=3, SESSION_SECS=3).
module tb_math_round_engine;

    localparam int unsigned OPW = 3;
    localparam int unsigned SCW = 8;
`ifdef SCORE_PENALTY_EN
    localparam int unsigned PEN = 1;
`else
    localparam int unsigned PEN = 0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           enable = 1'b0;
    logic           donot_borrow = 1'b0;
    logic           tick_1s = 1'b0;
    logic           rng_valid = 1'b0;
    logic [OPW-1:0] rng_value = '0;
    logic [OPW:0]   answer_sw = '0;
    logic           answer_push = 1'b0;
    logic           rng_req;
    logic [OPW-1:0] operand_a, operand_b;
    logic           op_sub;
    logic [SCW-1:0] score;
    logic           correct_led, wrong_led, busy, time_out;

    int n_vec = 0;
    int n_err = 0;

    math_round_engine #(
        .OPW          (OPW),
        .SESSION_SECS (3),
        .SCW          (SCW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .donot_borrow (donot_borrow),
        .tick_1s      (tick_1s),
        .rng_valid    (rng_valid),
        .rng_value    (rng_value),
        .answer_sw    (answer_sw),
        .answer_push  (answer_push),
        .rng_req      (rng_req),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .op_sub       (op_sub),
        .score        (score),
        .correct_led  (correct_led),
        .wrong_led    (wrong_led),
        .busy         (busy),
        .time_out     (time_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        tick_1s = 1'b1;
        step();
        tick_1s = 1'b0;
    endtask

    task automatic feed(input logic [OPW-1:0] v);
        for (int i = 0; i < 20 && !rng_req; i++) step();
        check_eq("rng_req_wait", rng_req, 1);
        rng_value = v;
        rng_valid = 1'b1;
        step();
        rng_valid = 1'b0;
    endtask

    task automatic push(input logic [OPW:0] ans);
        answer_sw   = ans;
        answer_push = 1'b1;
        step();
        answer_push = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_outs"}, {rng_req, operand_a, operand_b, op_sub, score,
                                  correct_led, wrong_led, busy, time_out}, 0);
    endtask

    initial begin
        #1;
        check_all_zero("reset");
        step();
        rst = 1'b0;
        step();
        check_eq("idle_busy", busy, 0);

        // Session 1: correct add/sub, wrong answer, expiry with coincident push.
        enable = 1'b1;
        step();
        check_eq("start_busy", busy, 1);
        check_eq("start_req", rng_req, 1);
        feed(3'd5);
        check_eq("after_a_req", rng_req, 0);
        feed(3'd2);
        check_eq("t2_ops", {operand_a, operand_b, op_sub}, {3'd5, 3'd2, 1'b1});
        push(4'd3);
        check_eq("t2_score", score, 1);
        check_eq("t2_leds", {correct_led, wrong_led}, 2'b10);
        step();
        check_eq("t2_led_hold", correct_led, 1);
        tick();
        check_eq("t2_led_clear", {correct_led, wrong_led}, 2'b00);
        check_eq("t2_next_req", rng_req, 1);
        feed(3'd3);
        feed(3'd3);
        check_eq("t4_op_add", op_sub, 0);
        push(4'd5);
        check_eq("t4_leds", {correct_led, wrong_led}, 2'b01);
        check_eq("t4_score", score, 1 - PEN);
        tick();
        check_eq("t4_led_clear", wrong_led, 0);
        feed(3'd1);
        feed(3'd2);
        check_eq("t5_ops", {operand_a, operand_b, op_sub}, {3'd1, 3'd2, 1'b1});
        answer_sw   = 4'd15;
        answer_push = 1'b1;
        tick_1s     = 1'b1;
        check_eq("t5_pre_tout", time_out, 0);
        step();
        answer_push = 1'b0;
        tick_1s     = 1'b0;
        check_eq("t5_tout", time_out, 1);
        check_eq("t5_busy", busy, 0);
        check_eq("t5_score", score, 1 - PEN);
        check_eq("t5_leds", {correct_led, wrong_led, rng_req}, 3'b000);
        step();
        check_eq("t5_tout_pulse", time_out, 0);
        tick();
        step();
        check_eq("done_hold", {busy, time_out, rng_req}, 3'b000);
        check_eq("done_ops", {operand_a, operand_b}, {3'd1, 3'd2});

        // Session 2: borrow guard, wrapped subtraction, enable drop in GET_B.
        enable = 1'b0;
        step();
        donot_borrow = 1'b1;
        enable       = 1'b1;
        step();
        check_eq("s2_score_clear", score, 0);
        feed(3'd2);
        feed(3'd7);
        check_eq("t3_swap", {operand_a, operand_b, op_sub}, {3'd7, 3'd2, 1'b1});
        push(4'd5);
        check_eq("t3_score", score, 1);
        tick();
        donot_borrow = 1'b0;
        feed(3'd2);
        feed(3'd7);
        check_eq("t3_noswap", {operand_a, operand_b, op_sub}, {3'd2, 3'd7, 1'b1});
        push(4'b1011);
        check_eq("t3_wrap_led", correct_led, 1);
        check_eq("t3_wrap_score", score, 2);
        tick();
        feed(3'd1);
        enable    = 1'b0;
        rng_value = 3'd6;
        rng_valid = 1'b1;
        step();
        rng_valid = 1'b0;
        check_eq("t6_idle", {busy, rng_req, correct_led, wrong_led}, 4'b0000);
        check_eq("t6_ops", {operand_a, operand_b}, {3'd1, 3'd7});
        check_eq("t6_score_held", score, 2);

        // Session 3: asynchronous reset while waiting in ASK.
        enable = 1'b1;
        step();
        feed(3'd5);
        feed(3'd2);
        check_eq("t1_ask_busy", busy, 1);
        #2;
        rst    = 1'b1;
        enable = 1'b0;
        #1;
        check_all_zero("t1_async");
        step();
        check_all_zero("t1_held");
        rst = 1'b0;
        step();
        check_eq("t1_after", {busy, time_out, rng_req}, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
